// File: rtl/evo_test_pkg.sv
// Shared types and constants for the evolved-circuit sampler harness.
// Provides the FSM state encoding, default parameters and the vector-count helper.
package evo_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int DEF_IN_WIDTH      = 4;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_SAMPLE_CYCLES = 32;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_CNT_WIDTH     = 16;

   function automatic int vec_count(input int in_width);
      return 1 << in_width;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
// Ports: clk, rst_n (async, active-low), d_i (async input), q_o (synchronized).
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/evolved_circuit_sampler.sv
// Sweeps every input vector onto an evolved circuit, settles, then samples its output.
// Ports: clk, rst_n, start -> busy/done; dut_in/dut_out to the circuit;
// truth_table, unstable_mask, toggle_count hold the results of the last sweep.
module evolved_circuit_sampler
   import evo_test_pkg::*;
#(
   parameter int IN_WIDTH      = DEF_IN_WIDTH,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   output logic [IN_WIDTH-1:0]            dut_in,
   input  logic                           dut_out,
   output logic                           busy,
   output logic                           done,
   output logic [vec_count(IN_WIDTH)-1:0] truth_table,
   output logic [vec_count(IN_WIDTH)-1:0] unstable_mask,
   output logic [CNT_WIDTH-1:0]           toggle_count
);

   localparam int NVEC   = vec_count(IN_WIDTH);
   localparam int PH_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                           SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(SAMPLE_CYCLES - 1);

   state_e                state_q, state_d;
   logic [IN_WIDTH-1:0]   vec_q, vec_d;
   logic [PH_W-1:0]       cnt_q, cnt_d;
   logic                  ref_q, ref_d;
   logic                  prev_q, prev_d;
   logic [NVEC-1:0]       tt_q, tt_d;
   logic [NVEC-1:0]       um_q, um_d;
   logic [CNT_WIDTH-1:0]  tc_q, tc_d;
   logic                  s;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (dut_out),
      .q_o   (s)
   );

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      ref_d   = ref_q;
      prev_d  = prev_q;
      tt_d    = tt_q;
      um_d    = um_q;
      tc_d    = tc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               vec_d   = '0;
               cnt_d   = '0;
               tt_d    = '0;
               um_d    = '0;
               tc_d    = '0;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            // First sample is both the stability reference and the
            // starting point for transition counting.
            if (cnt_q == '0) begin
               ref_d  = s;
               prev_d = s;
            end else begin
               if (s != ref_q) begin
                  um_d[vec_q] = 1'b1;
               end
               if ((s != prev_q) && (tc_q != '1)) begin
                  tc_d = tc_q + 1'b1;
               end
               prev_d = s;
            end
            if (cnt_q == SAMPLE_LAST) begin
               tt_d[vec_q] = s;
               cnt_d       = '0;
               if (vec_q == '1) begin
                  state_d = DONE;
               end else begin
                  vec_d   = vec_q + 1'b1;
                  state_d = SETTLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         ref_q   <= 1'b0;
         prev_q  <= 1'b0;
         tt_q    <= '0;
         um_q    <= '0;
         tc_q    <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         ref_q   <= ref_d;
         prev_q  <= prev_d;
         tt_q    <= tt_d;
         um_q    <= um_d;
         tc_q    <= tc_d;
      end
   end

   assign dut_in        = vec_q;
   assign busy          = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done          = (state_q == DONE);
   assign truth_table   = tt_q;
   assign unstable_mask = um_q;
   assign toggle_count  = tc_q;

endmodule

// File: tb/tb_evolved_circuit_sampler.sv
// Scoreboard bench for evolved_circuit_sampler with behavioural circuit models.
// Second instance with an 8-bit counter exercises toggle saturation.
module tb_evolved_circuit_sampler;

   typedef struct packed {
      logic [15:0] tt;
      logic [15:0] tt_mask;
      logic [15:0] um;
      int          tc_lo;
      int          tc_hi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  dut_in;
   logic        dut_out;
   logic        busy;
   logic        done;
   logic [15:0] tt;
   logic [15:0] um;
   logic [15:0] tc;

   logic        start2;
   logic [3:0]  dut_in2;
   logic        busy2;
   logic        done2;
   logic [15:0] tt2;
   logic [15:0] um2;
   logic [7:0]  tc2;

   int          mode = 0;
   logic [1:0]  osc_cnt = 2'd0;
   logic        osc_q = 1'b0;
   logic        tog_q = 1'b0;

   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;

   // Oscillates with a period of 8 clk (edge every 4) only on vector 5.
   always @(posedge clk) begin
      if (dut_in == 4'd5) begin
         osc_cnt <= osc_cnt + 2'd1;
         if (osc_cnt == 2'd3) osc_q <= ~osc_q;
      end else begin
         osc_cnt <= 2'd0;
         osc_q   <= 1'b0;
      end
   end

   always @(posedge clk) tog_q <= ~tog_q;

   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0: dut_out = dut_in[0] ^ dut_in[3];
         1: dut_out = 1'b1;
         2: dut_out = 1'b0;
         3: dut_out = osc_q;
         default: dut_out = 1'b0;
      endcase
   end

   evolved_circuit_sampler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .dut_in        (dut_in),
      .dut_out       (dut_out),
      .busy          (busy),
      .done          (done),
      .truth_table   (tt),
      .unstable_mask (um),
      .toggle_count  (tc)
   );

   evolved_circuit_sampler #(
      .CNT_WIDTH (8)
   ) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start2),
      .dut_in        (dut_in2),
      .dut_out       (tog_q),
      .busy          (busy2),
      .done          (done2),
      .truth_table   (tt2),
      .unstable_mask (um2),
      .toggle_count  (tc2)
   );

   // Drives one sweep, pushing its expectation when start is driven and
   // popping it when done appears. lat is the clk edge (counted from the
   // start edge as 0) that captures done, i.e. the cycle done is high in.
   task automatic sweep(input exp_t e, input int pa, input int pb,
                        output int lat, output int ndone,
                        output logic b1, output exp_t x);
      lat   = -1;
      ndone = 0;
      b1    = 1'b0;
      x     = e;
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(e);
      for (int c = 0; c <= 900; c++) begin
         @(negedge clk);
         start = (c == pa) || (c == pb);
         if (c == 0) b1 = busy;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = c + 1;
               if (exp_q.size() > 0) x = exp_q.pop_front();
            end
         end
         if (lat > 0 && c >= lat + 30) break;
      end
      start = 1'b0;
      if (lat < 0 && exp_q.size() > 0) x = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      #1;
      checks++;
      if ({busy, done, dut_in, tt, um, tc} !== 38'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {busy, done, dut_in, tt, um, tc});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=00", {busy, done});
      end
   endtask

   task automatic test_xor(input string nm, input int pa, input int pb);
      exp_t e, x;
      int lat, nd;
      logic b1;
      mode = 0;
      e = '{tt: 16'h55AA, tt_mask: 16'hFFFF, um: 16'h0000,
            tc_lo: 0, tc_hi: 0};
      sweep(e, pa, pb, lat, nd, b1, x);
      checks++;
      if (lat !== 769) begin
         failures++;
         $display("FAIL %s_latency got=%0d exp=769", nm, lat);
      end
      checks++;
      if (nd !== 1) begin
         failures++;
         $display("FAIL %s_done_pulses got=%0d exp=1", nm, nd);
      end
      checks++;
      if (b1 !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy got=%b exp=1", nm, b1);
      end
      checks++;
      if (tt !== x.tt) begin
         failures++;
         $display("FAIL %s_truth got=%h exp=%h", nm, tt, x.tt);
      end
      checks++;
      if (um !== x.um || tc !== 16'(x.tc_lo)) begin
         failures++;
         $display("FAIL %s_um_tc got=%h/%0d exp=%h/%0d",
                  nm, um, tc, x.um, x.tc_lo);
      end
   endtask

   task automatic test_const();
      exp_t e, x;
      int lat, nd;
      logic b1;
      for (int k = 1; k <= 2; k++) begin
         mode = k;
         e.tt      = (k == 1) ? 16'hFFFF : 16'h0000;
         e.tt_mask = 16'hFFFF;
         e.um      = 16'h0000;
         e.tc_lo   = 0;
         e.tc_hi   = 0;
         sweep(e, -1, -1, lat, nd, b1, x);
         checks++;
         if (lat !== 769 || nd !== 1) begin
            failures++;
            $display("FAIL const%0d_timing got=%0d/%0d exp=769/1",
                     k, lat, nd);
         end
         checks++;
         if (tt !== x.tt) begin
            failures++;
            $display("FAIL const%0d_truth got=%h exp=%h", k, tt, x.tt);
         end
         checks++;
         if (um !== x.um || tc !== 16'd0) begin
            failures++;
            $display("FAIL const%0d_um_tc got=%h/%0d exp=%h/0",
                     k, um, tc, x.um);
         end
      end
   endtask

   task automatic test_osc();
      exp_t e, x;
      int lat, nd;
      logic b1;
      mode = 3;
      e = '{tt: 16'h0000, tt_mask: 16'hFFDF, um: 16'h0020,
            tc_lo: 7, tc_hi: 8};
      sweep(e, -1, -1, lat, nd, b1, x);
      checks++;
      if ((tt & x.tt_mask) !== x.tt) begin
         failures++;
         $display("FAIL osc_truth got=%h exp=%h mask=%h",
                  tt, x.tt, x.tt_mask);
      end
      checks++;
      if (um !== x.um) begin
         failures++;
         $display("FAIL osc_unstable got=%h exp=%h", um, x.um);
      end
      checks++;
      if (int'(tc) < x.tc_lo || int'(tc) > x.tc_hi) begin
         failures++;
         $display("FAIL osc_toggles got=%0d exp=%0d..%0d",
                  tc, x.tc_lo, x.tc_hi);
      end
      checks++;
      if (lat !== 769) begin
         failures++;
         $display("FAIL osc_latency got=%0d exp=769", lat);
      end
   endtask

   task automatic test_mid_reset();
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (299) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, dut_in, tt, um, tc} !== 38'd0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h exp=0",
                  {busy, done, dut_in, tt, um, tc});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_xor("after_reset", -1, -1);
   endtask

   task automatic test_saturation();
      exp_t e, x;
      int lat;
      e = '{tt: 16'h0000, tt_mask: 16'h0000, um: 16'hFFFF,
            tc_lo: 255, tc_hi: 255};
      x = e;
      lat = -1;
      @(negedge clk);
      start2 = 1'b1;
      exp_q.push_back(e);
      for (int c = 0; c <= 900; c++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) begin
            lat = c + 1;
            x = exp_q.pop_front();
            break;
         end
      end
      if (lat < 0 && exp_q.size() > 0) x = exp_q.pop_front();
      checks++;
      if (lat !== 769) begin
         failures++;
         $display("FAIL sat_latency got=%0d exp=769", lat);
      end
      checks++;
      if (int'(tc2) !== x.tc_lo) begin
         failures++;
         $display("FAIL sat_toggles got=%0d exp=%0d", tc2, x.tc_lo);
      end
      checks++;
      if (um2 !== x.um) begin
         failures++;
         $display("FAIL sat_unstable got=%h exp=%h", um2, x.um);
      end
   endtask

   initial begin
      test_reset();
      test_xor("xor", -1, -1);
      test_const();
      test_osc();
      test_mid_reset();
      test_xor("ignore_start", 10, 400);
      test_saturation();
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/evolved_circuit_sampler.md
Name: evolved_circuit_sampler

Overview:
- Downstream harness stage for an evolved LCELL circuit under test (4-input, 1-output, combinational feedback that may settle or oscillate).
- Sweeps all 2**IN_WIDTH input vectors onto the circuit and waits a settle window per vector.
- Samples the circuit's asynchronous output through a synchronizer and records a truth table, a per-vector instability mask and a saturating toggle count.
- Results feed the fitness/readout logic.

Parameters:
- IN_WIDTH, 4: width of the circuit input vector; the sweep covers 2**IN_WIDTH vectors.
- SETTLE_CYCLES, 16: clk cycles a vector is held before sampling starts; must be >= SYNC_STAGES+1.
- SAMPLE_CYCLES, 32: clk cycles of observation per vector; must be >= 2.
- SYNC_STAGES, 2: flip-flop depth of the dut_out synchronizer.
- CNT_WIDTH, 16: width of toggle_count.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- dut_in  output  IN_WIDTH  vector driven onto the circuit under test.
- dut_out  input  1  raw, asynchronous output of the circuit under test.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the sweep completes.
- truth_table  output  2**IN_WIDTH  bit v = last synchronized sample taken for vector v.
- unstable_mask  output  2**IN_WIDTH  bit v = 1 if any sample for vector v differs from that vector's first sample.
- toggle_count  output  CNT_WIDTH  saturating count of synchronized-output transitions seen during SAMPLE windows.

Behaviour:
Reset and clocking:
- One clock domain. Reset is asynchronous and active-low: clk and rst_n.
- Reset values: dut_in=0, busy=0, done=0, truth_table=0, unstable_mask=0, toggle_count=0, state=IDLE, counters=0, synchronizer flops=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial results are retained.

State machine (IDLE, SETTLE, SAMPLE, DONE):
- IDLE: start=1 → clear truth_table, unstable_mask, toggle_count and vector index. Set dut_in=0, busy=1, go to SETTLE.
- SETTLE: hold dut_in, count SETTLE_CYCLES cycles, then go to SAMPLE. Nothing is recorded and toggles are not counted.
- SAMPLE: for SAMPLE_CYCLES cycles, read the synchronized output s.
  - Cycle 0 latches s as the reference and as the previous value.
  - Cycles 1..N-1: s != reference sets unstable_mask[v]; s != previous increments toggle_count, saturating at 2**CNT_WIDTH-1.
  - The final cycle writes truth_table[v]=s.
  - If v < 2**IN_WIDTH-1: increment v, drive dut_in=v+1, go to SETTLE.
  - Otherwise go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. dut_in is held at the last vector; results are held until the next accepted start.

Handshake and timing:
- start while busy is ignored; no queuing. start held high across DONE→IDLE restarts a sweep in IDLE.
- Latency: done is high in the cycle 2**IN_WIDTH*(SETTLE_CYCLES+SAMPLE_CYCLES)+1 cycles after the start edge. With defaults this is 769.
- dut_in changes only on the SAMPLE→SETTLE transition and when start is accepted. The tested circuit therefore never sees a vector change during sampling.
- truth_table, unstable_mask and toggle_count are registered outputs. They are valid when done pulses and remain stable in IDLE.

Decomposition:
- Shared package evo_test_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), default parameter constants, and a localparam function for the vector count (2**IN_WIDTH).
- One sub-module: bit_synchronizer, a SYNC_STAGES-deep flop chain with asynchronous active-low reset, instantiated on dut_out.
- The FSM and counters stay in the top module.

Test Plan:
- Model dut_out = in[0]^in[3], start pulse → done at cycle 769, truth_table=16'h55AA, unstable_mask=16'h0000, toggle_count=0.
- Model dut_out constant 1 → truth_table=16'hFFFF, unstable_mask=0, toggle_count=0. Then repeat with constant 0 → truth_table=16'h0000.
- Model oscillates (toggles every 4 clk) only when in==5, else 0 → unstable_mask=16'h0020, toggle_count in 7..8, truth_table bit 5 either value, all other bits 0.
- Assert rst_n=0 at cycle 300 mid-sweep → all outputs immediately 0 and busy=0. A new start then completes normally at 769 cycles with correct results.
- Pulse start again at cycles 10 and 400 while busy → ignored. Exactly one done pulse occurs and results match a single sweep.
- Model toggling every clk on all vectors with CNT_WIDTH=8 → toggle_count saturates at 255 and unstable_mask=16'hFFFF.
